// File: rtl/axi_lite_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter, one outstanding transaction per grant.
// Define AXI_LITE_ARB_RR_EN for round-robin arbitration; fixed priority (master 0 wins) otherwise.
module axi_lite_arbiter_2to1 #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,
  input  logic [2:0]            s0_axi_awprot,
  input  logic                  s0_axi_awvalid,
  output logic                  s0_axi_awready,
  input  logic [31:0]           s0_axi_wdata,
  input  logic [3:0]            s0_axi_wstrb,
  input  logic                  s0_axi_wvalid,
  output logic                  s0_axi_wready,
  output logic [1:0]            s0_axi_bresp,
  output logic                  s0_axi_bvalid,
  input  logic                  s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic [2:0]            s0_axi_arprot,
  input  logic                  s0_axi_arvalid,
  output logic                  s0_axi_arready,
  output logic [31:0]           s0_axi_rdata,
  output logic [1:0]            s0_axi_rresp,
  output logic                  s0_axi_rvalid,
  input  logic                  s0_axi_rready,
  input  logic [ADDR_WIDTH-1:0] s1_axi_awaddr,
  input  logic [2:0]            s1_axi_awprot,
  input  logic                  s1_axi_awvalid,
  output logic                  s1_axi_awready,
  input  logic [31:0]           s1_axi_wdata,
  input  logic [3:0]            s1_axi_wstrb,
  input  logic                  s1_axi_wvalid,
  output logic                  s1_axi_wready,
  output logic [1:0]            s1_axi_bresp,
  output logic                  s1_axi_bvalid,
  input  logic                  s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic [2:0]            s1_axi_arprot,
  input  logic                  s1_axi_arvalid,
  output logic                  s1_axi_arready,
  output logic [31:0]           s1_axi_rdata,
  output logic [1:0]            s1_axi_rresp,
  output logic                  s1_axi_rvalid,
  input  logic                  s1_axi_rready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  arb_busy,
  output logic                  arb_grant
);

  typedef enum logic [2:0] {S_IDLE, S_WR_ADDR, S_WR_RESP, S_RD_ADDR, S_RD_DATA} state_t;

  state_t r_state, w_state_nxt;
  logic   r_grant, w_grant_nxt;
  logic   r_last, w_last_nxt;
  logic   r_aw_done, w_aw_done_nxt;
  logic   r_w_done, w_w_done_nxt;

  logic [1:0] w_wr_req, w_req;
  logic       w_pick;

  logic [ADDR_WIDTH-1:0] w_sel_awaddr, w_sel_araddr;
  logic [2:0]            w_sel_awprot, w_sel_arprot;
  logic [31:0]           w_sel_wdata;
  logic [3:0]            w_sel_wstrb;
  logic w_sel_awvalid, w_sel_wvalid, w_sel_bready, w_sel_arvalid, w_sel_rready;
  logic w_aw_fire, w_w_fire;

  logic [1:0]       w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
  logic [1:0][1:0]  w_bresp, w_rresp;
  logic [1:0][31:0] w_rdata;

  assign w_wr_req = {s1_axi_awvalid & s1_axi_wvalid, s0_axi_awvalid & s0_axi_wvalid};
  assign w_req    = w_wr_req | {s1_axi_arvalid, s0_axi_arvalid};

`ifdef AXI_LITE_ARB_RR_EN
  assign w_pick = (w_req[0] & w_req[1]) ? ~r_last : w_req[1];
`else
  assign w_pick = ~w_req[0];
`endif

  assign w_sel_awaddr  = r_grant ? s1_axi_awaddr  : s0_axi_awaddr;
  assign w_sel_awprot  = r_grant ? s1_axi_awprot  : s0_axi_awprot;
  assign w_sel_awvalid = r_grant ? s1_axi_awvalid : s0_axi_awvalid;
  assign w_sel_wdata   = r_grant ? s1_axi_wdata   : s0_axi_wdata;
  assign w_sel_wstrb   = r_grant ? s1_axi_wstrb   : s0_axi_wstrb;
  assign w_sel_wvalid  = r_grant ? s1_axi_wvalid  : s0_axi_wvalid;
  assign w_sel_bready  = r_grant ? s1_axi_bready  : s0_axi_bready;
  assign w_sel_araddr  = r_grant ? s1_axi_araddr  : s0_axi_araddr;
  assign w_sel_arprot  = r_grant ? s1_axi_arprot  : s0_axi_arprot;
  assign w_sel_arvalid = r_grant ? s1_axi_arvalid : s0_axi_arvalid;
  assign w_sel_rready  = r_grant ? s1_axi_rready  : s0_axi_rready;

  // Completed AW/W handshakes are masked so each is presented to the slave once.
  assign w_aw_fire = w_sel_awvalid & ~r_aw_done & m_axi_awready;
  assign w_w_fire  = w_sel_wvalid  & ~r_w_done  & m_axi_wready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_last    <= w_last_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    m_axi_awaddr  = '0;
    m_axi_awprot  = '0;
    m_axi_awvalid = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wstrb   = '0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arprot  = '0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    w_awready     = '0;
    w_wready      = '0;
    w_bvalid      = '0;
    w_bresp       = '0;
    w_arready     = '0;
    w_rvalid      = '0;
    w_rresp       = '0;
    w_rdata       = '0;
    unique case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_grant_nxt = w_pick;
          w_state_nxt = w_wr_req[w_pick] ? S_WR_ADDR : S_RD_ADDR;
        end
      end
      S_WR_ADDR: begin
        m_axi_awaddr       = w_sel_awaddr;
        m_axi_awprot       = w_sel_awprot;
        m_axi_awvalid      = w_sel_awvalid & ~r_aw_done;
        m_axi_wdata        = w_sel_wdata;
        m_axi_wstrb        = w_sel_wstrb;
        m_axi_wvalid       = w_sel_wvalid & ~r_w_done;
        w_awready[r_grant] = m_axi_awready & ~r_aw_done;
        w_wready[r_grant]  = m_axi_wready & ~r_w_done;
        w_aw_done_nxt      = r_aw_done | w_aw_fire;
        w_w_done_nxt       = r_w_done | w_w_fire;
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_state_nxt   = S_WR_RESP;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      S_WR_RESP: begin
        m_axi_bready      = w_sel_bready;
        w_bvalid[r_grant] = m_axi_bvalid;
        w_bresp[r_grant]  = m_axi_bresp;
        if (m_axi_bvalid && w_sel_bready) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_grant;
        end
      end
      S_RD_ADDR: begin
        m_axi_araddr       = w_sel_araddr;
        m_axi_arprot       = w_sel_arprot;
        m_axi_arvalid      = w_sel_arvalid;
        w_arready[r_grant] = m_axi_arready;
        if (w_sel_arvalid && m_axi_arready) w_state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        m_axi_rready      = w_sel_rready;
        w_rvalid[r_grant] = m_axi_rvalid;
        w_rresp[r_grant]  = m_axi_rresp;
        w_rdata[r_grant]  = m_axi_rdata;
        if (m_axi_rvalid && w_sel_rready) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_grant;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign s0_axi_awready = w_awready[0];
  assign s0_axi_wready  = w_wready[0];
  assign s0_axi_bvalid  = w_bvalid[0];
  assign s0_axi_bresp   = w_bresp[0];
  assign s0_axi_arready = w_arready[0];
  assign s0_axi_rvalid  = w_rvalid[0];
  assign s0_axi_rresp   = w_rresp[0];
  assign s0_axi_rdata   = w_rdata[0];
  assign s1_axi_awready = w_awready[1];
  assign s1_axi_wready  = w_wready[1];
  assign s1_axi_bvalid  = w_bvalid[1];
  assign s1_axi_bresp   = w_bresp[1];
  assign s1_axi_arready = w_arready[1];
  assign s1_axi_rvalid  = w_rvalid[1];
  assign s1_axi_rresp   = w_rresp[1];
  assign s1_axi_rdata   = w_rdata[1];

  assign arb_busy  = (r_state != S_IDLE);
  assign arb_grant = r_grant;

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Directed self-checking bench for axi_lite_arbiter_2to1; the bench itself plays both masters and the slave.
module tb_axi_lite_arbiter_2to1;
  localparam int AW = 4;

  logic          aclk, aresetn;
  logic [AW-1:0] s0_axi_awaddr, s1_axi_awaddr, s0_axi_araddr, s1_axi_araddr;
  logic [2:0]    s0_axi_awprot, s1_axi_awprot, s0_axi_arprot, s1_axi_arprot;
  logic          s0_axi_awvalid, s1_axi_awvalid, s0_axi_awready, s1_axi_awready;
  logic [31:0]   s0_axi_wdata, s1_axi_wdata, s0_axi_rdata, s1_axi_rdata;
  logic [3:0]    s0_axi_wstrb, s1_axi_wstrb;
  logic          s0_axi_wvalid, s1_axi_wvalid, s0_axi_wready, s1_axi_wready;
  logic [1:0]    s0_axi_bresp, s1_axi_bresp, s0_axi_rresp, s1_axi_rresp;
  logic          s0_axi_bvalid, s1_axi_bvalid, s0_axi_bready, s1_axi_bready;
  logic          s0_axi_arvalid, s1_axi_arvalid, s0_axi_arready, s1_axi_arready;
  logic          s0_axi_rvalid, s1_axi_rvalid, s0_axi_rready, s1_axi_rready;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0]   m_axi_wdata, m_axi_rdata;
  logic [3:0]    m_axi_wstrb;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready;
  logic          arb_busy, arb_grant;

  int n_checks = 0;
  int n_errors = 0;

  axi_lite_arbiter_2to1 #(.ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awprot(s0_axi_awprot), .s0_axi_awvalid(s0_axi_awvalid),
    .s0_axi_awready(s0_axi_awready), .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb),
    .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready), .s0_axi_bresp(s0_axi_bresp),
    .s0_axi_bvalid(s0_axi_bvalid), .s0_axi_bready(s0_axi_bready), .s0_axi_araddr(s0_axi_araddr),
    .s0_axi_arprot(s0_axi_arprot), .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
    .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp), .s0_axi_rvalid(s0_axi_rvalid),
    .s0_axi_rready(s0_axi_rready),
    .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awprot(s1_axi_awprot), .s1_axi_awvalid(s1_axi_awvalid),
    .s1_axi_awready(s1_axi_awready), .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb),
    .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready), .s1_axi_bresp(s1_axi_bresp),
    .s1_axi_bvalid(s1_axi_bvalid), .s1_axi_bready(s1_axi_bready), .s1_axi_araddr(s1_axi_araddr),
    .s1_axi_arprot(s1_axi_arprot), .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
    .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp), .s1_axi_rvalid(s1_axi_rvalid),
    .s1_axi_rready(s1_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .arb_busy(arb_busy), .arb_grant(arb_grant)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    {s0_axi_awaddr, s0_axi_awprot, s0_axi_awvalid, s0_axi_wdata, s0_axi_wstrb, s0_axi_wvalid} = '0;
    {s0_axi_bready, s0_axi_araddr, s0_axi_arprot, s0_axi_arvalid, s0_axi_rready} = '0;
    {s1_axi_awaddr, s1_axi_awprot, s1_axi_awvalid, s1_axi_wdata, s1_axi_wstrb, s1_axi_wvalid} = '0;
    {s1_axi_bready, s1_axi_araddr, s1_axi_arprot, s1_axi_arvalid, s1_axi_rready} = '0;
    {m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid, m_axi_arready} = '0;
    {m_axi_rdata, m_axi_rresp, m_axi_rvalid} = '0;
  endtask

  // Single s0 write with an always-ready slave, starting and ending in IDLE.
  task automatic s0_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
    s0_axi_awaddr = addr; s0_axi_awvalid = 1'b1;
    s0_axi_wdata = data;  s0_axi_wstrb = strb; s0_axi_wvalid = 1'b1;
    #1;
    check("wr_idle_m_awvalid", m_axi_awvalid, 0);
    check("wr_idle_s0_awready", s0_axi_awready, 0);
    tick();
    check("wr_m_awvalid", m_axi_awvalid, 1);
    check("wr_m_wvalid", m_axi_wvalid, 1);
    check("wr_m_awaddr", m_axi_awaddr, addr);
    check("wr_m_wdata", m_axi_wdata, data);
    check("wr_m_wstrb", m_axi_wstrb, strb);
    check("wr_busy", arb_busy, 1);
    check("wr_grant", arb_grant, 0);
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    #1;
    check("wr_s0_awready", s0_axi_awready, 1);
    check("wr_s0_wready", s0_axi_wready, 1);
    check("wr_s1_wready", s1_axi_wready, 0);
    tick();
    s0_axi_awvalid = 1'b0; s0_axi_wvalid = 1'b0;
    m_axi_awready = 1'b0;  m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b1;   m_axi_bresp = 2'b00; s0_axi_bready = 1'b1;
    #1;
    check("wr_resp_m_awvalid", m_axi_awvalid, 0);
    check("wr_s0_bvalid", s0_axi_bvalid, 1);
    check("wr_s0_bresp", s0_axi_bresp, 0);
    check("wr_s1_bvalid", s1_axi_bvalid, 0);
    check("wr_m_bready", m_axi_bready, 1);
    tick();
    m_axi_bvalid = 1'b0; s0_axi_bready = 1'b0;
    #1;
    check("wr_done_idle", arb_busy, 0);
  endtask

  logic [3:0] exp_tie;

  initial begin
    aresetn = 1'b0;
    clear_inputs();
    #2;
    check("rst_busy", arb_busy, 0);
    check("rst_grant", arb_grant, 0);
    check("rst_s0_awready", s0_axi_awready, 0);
    check("rst_s1_arready", s1_axi_arready, 0);
    check("rst_m_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
    check("rst_s_bvalid_rvalid", {s0_axi_bvalid, s1_axi_bvalid, s0_axi_rvalid, s1_axi_rvalid}, 0);
    check("rst_data", {m_axi_awaddr, m_axi_wdata, s0_axi_rdata[15:0]}, 0);
    tick(); tick();
    aresetn = 1'b1;
    tick();

    // Single write from s0.
    s0_write(4'h0, 32'h0000_00A5, 4'h1);

    // Single read from s1 at 0x4.
    s1_axi_araddr = 4'h4; s1_axi_arvalid = 1'b1;
    tick();
    check("rd_grant", arb_grant, 1);
    check("rd_m_arvalid", m_axi_arvalid, 1);
    check("rd_m_araddr", m_axi_araddr, 4'h4);
    m_axi_arready = 1'b1;
    #1;
    check("rd_s1_arready", s1_axi_arready, 1);
    check("rd_s0_arready", s0_axi_arready, 0);
    tick();
    s1_axi_arvalid = 1'b0; m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0000_00FF; m_axi_rresp = 2'b00; s1_axi_rready = 1'b1;
    #1;
    check("rd_s1_rvalid", s1_axi_rvalid, 1);
    check("rd_s1_rdata", s1_axi_rdata, 32'h0000_00FF);
    check("rd_s1_rresp", s1_axi_rresp, 0);
    check("rd_s0_rdata", s0_axi_rdata, 0);
    check("rd_s0_rvalid", s0_axi_rvalid, 0);
    check("rd_data_grant", arb_grant, 1);
    tick();
    m_axi_rvalid = 1'b0; m_axi_rdata = '0; s1_axi_rready = 1'b0;
    #1;
    check("rd_done_idle", arb_busy, 0);

    // Tie: both masters continuously request writes; last-granted is 1 here.
`ifdef AXI_LITE_ARB_RR_EN
    exp_tie = 4'b1010;
`else
    exp_tie = 4'b0000;
`endif
    s0_axi_awvalid = 1'b1; s0_axi_wvalid = 1'b1; s0_axi_bready = 1'b1;
    s1_axi_awvalid = 1'b1; s1_axi_wvalid = 1'b1; s1_axi_bready = 1'b1;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1;
    for (int r = 0; r < 4; r++) begin
      tick();
      check($sformatf("tie_grant_%0d", r), arb_grant, exp_tie[r]);
      tick();
      tick();
      check($sformatf("tie_idle_gap_%0d", r), arb_busy, 0);
    end
    clear_inputs();

    // Staggered AW/W: awready one cycle before wready, AW valid held high by the master.
    s0_axi_awaddr = 4'h8; s0_axi_awvalid = 1'b1;
    s0_axi_wdata = 32'h1234_5678; s0_axi_wstrb = 4'hF; s0_axi_wvalid = 1'b1; s0_axi_bready = 1'b1;
    tick();
    m_axi_awready = 1'b1;
    #1;
    check("stg_s0_awready", s0_axi_awready, 1);
    check("stg_s0_wready", s0_axi_wready, 0);
    tick();
    m_axi_awready = 1'b0; m_axi_wready = 1'b1;
    #1;
    check("stg_m_awvalid_once", m_axi_awvalid, 0);
    check("stg_m_wvalid", m_axi_wvalid, 1);
    check("stg_s0_wready2", s0_axi_wready, 1);
    check("stg_no_resp_yet", m_axi_bready, 0);
    check("stg_busy", arb_busy, 1);
    tick();
    s0_axi_awvalid = 1'b0; s0_axi_wvalid = 1'b0; m_axi_wready = 1'b0;
    s0_axi_bready = 1'b0;
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
    s1_axi_araddr = 4'hC; s1_axi_arvalid = 1'b1;
    #1;
    check("stg_m_wvalid_done", m_axi_wvalid, 0);

    // Back-pressure on B for 5 cycles while s1 waits with a read.
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_s0_bvalid_%0d", c), s0_axi_bvalid, 1);
      check($sformatf("bp_s0_bresp_%0d", c), s0_axi_bresp, 2'b10);
      check($sformatf("bp_m_arvalid_%0d", c), m_axi_arvalid, 0);
      check($sformatf("bp_grant_%0d", c), arb_grant, 0);
      tick();
    end
    s0_axi_bready = 1'b1;
    #1;
    check("bp_m_bready", m_axi_bready, 1);
    tick();
    s0_axi_bready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    #1;
    check("bp_idle_gap", arb_busy, 0);
    check("bp_idle_m_arvalid", m_axi_arvalid, 0);
    tick();
    check("bp_s1_granted", arb_grant, 1);
    check("bp_s1_m_arvalid", m_axi_arvalid, 1);
    check("bp_s1_m_araddr", m_axi_araddr, 4'hC);

    // Reset asserted during RD_DATA.
    m_axi_arready = 1'b1;
    tick();
    s1_axi_arvalid = 1'b0; m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hDEAD_BEEF; s1_axi_rready = 1'b1;
    #1;
    check("rstmid_rvalid_before", s1_axi_rvalid, 1);
    check("rstmid_rdata_before", s1_axi_rdata, 32'hDEAD_BEEF);
    #1;
    aresetn = 1'b0;
    #1;
    check("rstmid_s1_rvalid", s1_axi_rvalid, 0);
    check("rstmid_s1_rdata", s1_axi_rdata, 0);
    check("rstmid_m_rready", m_axi_rready, 0);
    check("rstmid_busy", arb_busy, 0);
    check("rstmid_grant", arb_grant, 0);
    clear_inputs();
    tick();
    aresetn = 1'b1;
    tick();
    s0_write(4'h2, 32'h0000_5A5A, 4'h3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
